// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and shift-level placement helpers for pipelined_shifter
package shifter_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_ROR = 2'b01,
      OP_SRL = 2'b10,
      OP_SRA = 2'b11
   } op_e;

   function automatic int level_stage(input int level, input int stages, input int levels);
      return (level * stages) / levels;
   endfunction

   // Lowest level owned by a stage; a stage index past the end yields levels.
   function automatic int stage_first_level(input int stage, input int stages, input int levels);
      int first;
      first = levels;
      for (int j = levels - 1; j >= 0; j--) begin
         if (level_stage(j, stages, levels) >= stage) first = j;
      end
      return first;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one pipeline stage: shift levels FIRST_LEVEL..LAST_LEVEL plus its register slice
// SHIFTER_ROTATE_EN enables rotate-right on op 01; otherwise op 01 shifts left.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_WIDTH   = 5,
   parameter int FIRST_LEVEL = 0,
   parameter int LAST_LEVEL  = 0,
   localparam int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  prev_valid,
   input  logic [DATA_WIDTH-1:0] prev_data,
   input  logic [AMT_WIDTH-1:0]  prev_amt,
   input  op_e                   prev_op,
   input  logic [TAG_WIDTH-1:0]  prev_tag,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic [AMT_WIDTH-1:0]  amt,
   output op_e                   op,
   output logic [TAG_WIDTH-1:0]  tag
);

   logic [DATA_WIDTH-1:0] shifted;
`ifdef SHIFTER_ROTATE_EN
   logic [2*DATA_WIDTH-1:0] wrap;
`endif

   // SRA keeps the MSB at the sign value, so later levels still fill correctly.
   always_comb begin
      shifted = prev_data;
`ifdef SHIFTER_ROTATE_EN
      wrap = '0;
`endif
      for (int j = FIRST_LEVEL; j <= LAST_LEVEL; j++) begin
         if (prev_amt[AMT_WIDTH'(j)]) begin
            case (prev_op)
               OP_SRL: shifted = shifted >> (2 ** j);
               OP_SRA: shifted = $signed(shifted) >>> (2 ** j);
`ifdef SHIFTER_ROTATE_EN
               OP_ROR: begin
                  wrap    = {shifted, shifted} >> (2 ** j);
                  shifted = wrap[DATA_WIDTH-1:0];
               end
`endif
               default: shifted = shifted << (2 ** j);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         amt   <= '0;
         op    <= OP_SLL;
         tag   <= '0;
      end else if (load) begin
         valid <= prev_valid;
         if (prev_valid) begin
            data <= shifted;
            amt  <= prev_amt;
            op   <= prev_op;
            tag  <= prev_tag;
         end
      end
   end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - STAGES-deep barrel shifter with valid/ready flow control and tag pass-through
// SHIFTER_ROTATE_EN (in shift_stage) selects rotate-right for op 01.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 2,
   parameter int TAG_WIDTH  = 5,
   localparam int LEVELS    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [LEVELS-1:0]     in_b,
   input  logic [1:0]            in_op,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   // Index 0 is the request port, index i+1 is the register of stage i.
   logic [STAGES:0]       v_c;
   logic [DATA_WIDTH-1:0] d_c [STAGES+1];
   logic [LEVELS-1:0]     a_c [STAGES+1];
   op_e                   o_c [STAGES+1];
   logic [TAG_WIDTH-1:0]  t_c [STAGES+1];
   logic [STAGES-1:0]     adv;
   logic [STAGES-1:0]     load;
   logic                  unused_tail;

   assign v_c[0] = in_valid;
   assign d_c[0] = in_a;
   assign a_c[0] = in_b;
   assign o_c[0] = op_e'(in_op);
   assign t_c[0] = in_tag;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam int FIRST = stage_first_level(i, STAGES, LEVELS);
      localparam int LAST  = stage_first_level(i + 1, STAGES, LEVELS) - 1;

      // A stage's content moves on if the consumer takes it or any later stage has a hole.
      if (i == STAGES - 1) begin : g_tail
         assign adv[i] = out_ready;
      end else begin : g_body
         assign adv[i] = out_ready | ~(&v_c[STAGES:i+2]);
      end

      shift_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH),
         .FIRST_LEVEL(FIRST),
         .LAST_LEVEL (LAST)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[i]),
         .prev_valid(v_c[i]),
         .prev_data (d_c[i]),
         .prev_amt  (a_c[i]),
         .prev_op   (o_c[i]),
         .prev_tag  (t_c[i]),
         .valid     (v_c[i+1]),
         .data      (d_c[i+1]),
         .amt       (a_c[i+1]),
         .op        (o_c[i+1]),
         .tag       (t_c[i+1])
      );
   end

   assign load        = ~v_c[STAGES:1] | adv;
   assign in_ready    = load[0];
   assign out_valid   = v_c[STAGES];
   assign out_result  = d_c[STAGES];
   assign out_tag     = t_c[STAGES];
   assign unused_tail = ^{a_c[STAGES], o_c[STAGES]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed bench for pipelined_shifter at STAGES 1, 2 and 5
module tb_pipelined_shifter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_a = '0;
   logic [4:0]  in_b = '0;
   logic [1:0]  in_op = '0;
   logic [4:0]  in_tag = '0;

   logic        in_ready_1, in_ready_2, in_ready_5;
   logic        out_valid_1, out_valid_2, out_valid_5;
   logic [31:0] out_result_1, out_result_2, out_result_5;
   logic [4:0]  out_tag_1, out_tag_2, out_tag_5;

   int checks = 0;
   int errors = 0;

`ifdef SHIFTER_ROTATE_EN
   localparam logic [31:0] EXP_ROR4  = 32'h1000_000F;
   localparam logic [31:0] EXP_ROR12 = 32'h6781_2345;
`else
   localparam logic [31:0] EXP_ROR4  = 32'h0000_0F10;
   localparam logic [31:0] EXP_ROR12 = 32'h4567_8000;
`endif

   pipelined_shifter #(.DATA_WIDTH(32), .STAGES(2), .TAG_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid_2), .out_ready(out_ready), .out_result(out_result_2), .out_tag(out_tag_2));

   pipelined_shifter #(.DATA_WIDTH(32), .STAGES(1), .TAG_WIDTH(5)) dut_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_1),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid_1), .out_ready(out_ready), .out_result(out_result_1), .out_tag(out_tag_1));

   pipelined_shifter #(.DATA_WIDTH(32), .STAGES(5), .TAG_WIDTH(5)) dut_s5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_5),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid_5), .out_ready(out_ready), .out_result(out_result_5), .out_tag(out_tag_5));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] b,
                         input logic [1:0] op, input logic [4:0] tag, input logic [31:0] expected);
      int lat;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
      #1 check({name, "_rdy"}, 32'(in_ready_2), 1);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid_2 && lat < 20) begin
         tick();
         lat++;
      end
      check({name, "_lat"}, lat, 2);
      check({name, "_res"}, out_result_2, expected);
      check({name, "_tag"}, 32'(out_tag_2), 32'(tag));
      tick();
   endtask

   task automatic sweep(input string name, input logic [31:0] a, input logic [4:0] b,
                        input logic [1:0] op, input logic [4:0] tag, input logic [31:0] expected);
      int lat1, lat2, lat5;
      logic [31:0] res1, res5;
      logic [4:0]  tag5;
      lat1 = 0; lat2 = 0; lat5 = 0; res1 = '0; res5 = '0; tag5 = '0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
      #1 check({name, "_rdy1"}, 32'(in_ready_1), 1);
      check({name, "_rdy5"}, 32'(in_ready_5), 1);
      tick();
      in_valid = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         if (out_valid_1 && lat1 == 0) begin lat1 = n; res1 = out_result_1; end
         if (out_valid_2 && lat2 == 0) lat2 = n;
         if (out_valid_5 && lat5 == 0) begin lat5 = n; res5 = out_result_5; tag5 = out_tag_5; end
         tick();
      end
      check({name, "_lat1"}, lat1, 1);
      check({name, "_lat2"}, lat2, 2);
      check({name, "_lat5"}, lat5, 5);
      check({name, "_res1"}, res1, expected);
      check({name, "_res5"}, res5, expected);
      check({name, "_tag5"}, 32'(tag5), 32'(tag));
   endtask

   logic [31:0] stream_exp [8] = '{32'd0, 32'd2, 32'd8, 32'd24, 32'd64, 32'd160, 32'd384, 32'd896};
   logic [31:0] bp_a   [3] = '{32'h0000_00F0, 32'h0000_0001, 32'h8000_0000};
   logic [4:0]  bp_b   [3] = '{5'd4, 5'd1, 5'd1};
   logic [1:0]  bp_op  [3] = '{2'b10, 2'b00, 2'b11};
   logic [31:0] bp_exp [3] = '{32'h0000_000F, 32'h0000_0002, 32'hC000_0000};

   initial begin
      int n_in, n_out, first, last, stray, idx;
      logic acc;

      // Reset state
      repeat (3) tick();
      check("rst_valid", 32'(out_valid_2), 0);
      check("rst_result", out_result_2, 0);
      check("rst_tag", 32'(out_tag_2), 0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready_2), 1);

      // Single operations
      run_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 5'd3, 32'h8000_0000);
      run_op("sra4", 32'h8000_0000, 5'd4, 2'b11, 5'd4, 32'hF800_0000);
      run_op("srl4", 32'h8000_0000, 5'd4, 2'b10, 5'd5, 32'h0800_0000);
      run_op("b0_sll", 32'hA5A5_1234, 5'd0, 2'b00, 5'd6, 32'hA5A5_1234);
      run_op("b0_ror", 32'hA5A5_1234, 5'd0, 2'b01, 5'd7, 32'hA5A5_1234);
      run_op("b0_srl", 32'hA5A5_1234, 5'd0, 2'b10, 5'd8, 32'hA5A5_1234);
      run_op("b0_sra", 32'hA5A5_1234, 5'd0, 2'b11, 5'd9, 32'hA5A5_1234);
      run_op("sra31n", 32'h8000_0001, 5'd31, 2'b11, 5'd10, 32'hFFFF_FFFF);
      run_op("sra31p", 32'h7FFF_FFFF, 5'd31, 2'b11, 5'd11, 32'h0000_0000);
      run_op("sll8", 32'h1234_5678, 5'd8, 2'b00, 5'd12, 32'h3456_7800);
      run_op("srl5", 32'h1234_5678, 5'd5, 2'b10, 5'd13, 32'h0091_A2B3);
      run_op("ror4", 32'h0000_00F1, 5'd4, 2'b01, 5'd14, EXP_ROR4);
      run_op("ror12", 32'h1234_5678, 5'd12, 2'b01, 5'd15, EXP_ROR12);

      // Back-to-back stream: op k is (k << k), tag 16+k
      out_ready = 1'b1;
      n_in = 0; n_out = 0; first = -1; last = -1;
      for (int c = 0; c < 16; c++) begin
         if (out_valid_2) begin
            if (n_out < 8) begin
               check($sformatf("stream_res%0d", n_out), out_result_2, stream_exp[n_out]);
               check($sformatf("stream_tag%0d", n_out), 32'(out_tag_2), 32'(16 + n_out));
            end
            if (first < 0) first = c;
            last = c;
            n_out++;
         end
         in_valid = (n_in < 8);
         in_a = 32'(n_in); in_b = 5'(n_in); in_op = 2'b00; in_tag = 5'(16 + n_in);
         #1 acc = in_valid & in_ready_2;
         tick();
         if (acc) n_in++;
      end
      in_valid = 1'b0;
      check("stream_count", n_out, 8);
      check("stream_span", last - first, 7);

      // Backpressure: three offered, two fit
      out_ready = 1'b0;
      n_in = 0;
      for (int c = 0; c < 6; c++) begin
         idx = (n_in < 3) ? n_in : 2;
         in_valid = (n_in < 3);
         in_a = bp_a[idx]; in_b = bp_b[idx]; in_op = bp_op[idx]; in_tag = 5'(20 + idx);
         #1 acc = in_valid & in_ready_2;
         tick();
         if (acc) n_in++;
      end
      #1;
      check("bp_accepted", n_in, 2);
      check("bp_in_ready", 32'(in_ready_2), 0);
      check("bp_valid", 32'(out_valid_2), 1);
      check("bp_res", out_result_2, 32'h0000_000F);
      check("bp_tag", 32'(out_tag_2), 20);
      tick();
      tick();
      check("bp_hold_valid", 32'(out_valid_2), 1);
      check("bp_hold_res", out_result_2, 32'h0000_000F);
      check("bp_hold_tag", 32'(out_tag_2), 20);
      out_ready = 1'b1;
      n_out = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid_2) begin
            if (n_out < 3) begin
               check($sformatf("bp_out_res%0d", n_out), out_result_2, bp_exp[n_out]);
               check($sformatf("bp_out_tag%0d", n_out), 32'(out_tag_2), 32'(20 + n_out));
            end
            n_out++;
         end
         idx = (n_in < 3) ? n_in : 2;
         in_valid = (n_in < 3);
         in_a = bp_a[idx]; in_b = bp_b[idx]; in_op = bp_op[idx]; in_tag = 5'(20 + idx);
         #1 acc = in_valid & in_ready_2;
         tick();
         if (acc) n_in++;
      end
      in_valid = 1'b0;
      check("bp_out_count", n_out, 3);
      check("bp_drained", 32'(out_valid_2), 0);

      // Asynchronous reset with two operations held in flight
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1; in_a = 32'h0000_0001; in_b = 5'd1; in_op = 2'b00; in_tag = 5'(25 + c);
         tick();
      end
      in_valid = 1'b0;
      check("pre_rst_valid", 32'(out_valid_2), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid_2), 0);
      check("arst_result", out_result_2, 0);
      check("arst_tag", 32'(out_tag_2), 0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid_2 || out_valid_1 || out_valid_5) stray++;
         tick();
      end
      check("arst_no_stale", stray, 0);

      // Latency sweep across STAGES 1, 2, 5
      sweep("sw_sra", 32'h8000_0000, 5'd31, 2'b11, 5'd30, 32'hFFFF_FFFF);
      sweep("sw_srl", 32'hF000_0000, 5'd28, 2'b10, 5'd17, 32'h0000_000F);
      sweep("sw_sll", 32'h0000_0003, 5'd30, 2'b00, 5'd2, 32'hC000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
